// File: rtl/light_sequence_monitor_pkg.sv
// rtl/light_sequence_monitor_pkg.sv - shared light encodings, fault codes and monitor FSM states
package light_sequence_monitor_pkg;

   localparam logic [2:0] LIGHT_RED = 3'b001;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b100;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_ILLEGAL = 3'd1;
   localparam logic [2:0] FC_ORDER   = 3'd2;
   localparam logic [2:0] FC_SHORT   = 3'd3;
   localparam logic [2:0] FC_LONG    = 3'd4;

   localparam logic [1:0] SEL_RED = 2'd0;
   localparam logic [1:0] SEL_YEL = 2'd1;
   localparam logic [1:0] SEL_GRN = 2'd2;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_RED,
      ST_YEL,
      ST_GRN,
      ST_FAULT
   } state_t;

   function automatic logic is_one_hot(input logic [2:0] v);
      return (v == LIGHT_RED) || (v == LIGHT_YEL) || (v == LIGHT_GRN);
   endfunction

endpackage

// File: rtl/light_sequence_monitor_dwell_timer.sv
// rtl/light_sequence_monitor_dwell_timer.sv - saturating per-phase tick counter with short/long dwell compare
module dwell_timer #(
   parameter int CNT_W = 5,
   parameter int TOL   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             tick,
   input  logic [CNT_W:0]   exp_dwell,
   output logic [CNT_W:0]   dwell,
   output logic             short_dwell,
   output logic             long_dwell
);

   localparam int DW = CNT_W + 1;
   localparam logic [DW-1:0] SAT = '1;

   logic [DW-1:0] count_q, count_d;
   logic [DW-1:0] exp_q, exp_d;
   logic [DW-1:0] dwell_now;
   logic [DW+1:0] dwell_ext, exp_ext, tol_ext;

   // dwell_now includes a tick landing on this cycle, so a coincident phase
   // change credits it to the outgoing phase; compares use the latched expectation.
   always_comb begin
      dwell_now   = (tick && (count_q != SAT)) ? count_q + 1'b1 : count_q;
      count_d     = clear ? '0 : dwell_now;
      exp_d       = clear ? exp_dwell : exp_q;
      dwell_ext   = {2'b00, dwell_now};
      exp_ext     = {2'b00, exp_q};
      tol_ext     = (DW+2)'(TOL);
      short_dwell = (dwell_ext + tol_ext) < exp_ext;
      long_dwell  = dwell_ext > (exp_ext + tol_ext);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         exp_q   <= '0;
      end else begin
         count_q <= count_d;
         exp_q   <= exp_d;
      end
   end

   assign dwell = dwell_now;

endmodule

// File: rtl/light_sequence_monitor.sv
// rtl/light_sequence_monitor.sv - watchdog checking light order and per-phase dwell against a duration table
module light_sequence_monitor
   import light_sequence_monitor_pkg::*;
#(
   parameter int CNT_W   = 5,
   parameter int TOL     = 1,
   parameter int DEF_RED = 10,
   parameter int DEF_YEL = 3,
   parameter int DEF_GRN = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [2:0]       light,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_dur,
   input  logic             err_clear,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W:0]   last_dwell,
   output logic             phase_done,
   output logic [7:0]       cycle_count
);

   state_t           state_q, state_d;
   logic [2:0]       light_q;
   logic [CNT_W-1:0] dur_red_q, dur_red_d;
   logic [CNT_W-1:0] dur_yel_q, dur_yel_d;
   logic [CNT_W-1:0] dur_grn_q, dur_grn_d;
   logic             fault_q, fault_d;
   logic [2:0]       fault_code_q, fault_code_d;
   logic [CNT_W:0]   last_dwell_q, last_dwell_d;
   logic             phase_done_q, phase_done_d;
   logic [7:0]       cycle_count_q, cycle_count_d;

   logic             changed, legal;
   logic [2:0]       succ_light;
   state_t           succ_state;
   logic [1:0]       succ_sel, entry_sel;
   logic [CNT_W-1:0] entry_dur;
   logic [CNT_W:0]   exp_dwell, dwell;
   logic             timer_clear, short_dwell, long_dwell;

   dwell_timer #(.CNT_W(CNT_W), .TOL(TOL)) u_dwell_timer (
      .clk         (clk),
      .reset       (reset),
      .clear       (timer_clear),
      .tick        (tick),
      .exp_dwell   (exp_dwell),
      .dwell       (dwell),
      .short_dwell (short_dwell),
      .long_dwell  (long_dwell)
   );

   always_comb begin
      dur_red_d = dur_red_q;
      dur_yel_d = dur_yel_q;
      dur_grn_d = dur_grn_q;
      if (cfg_we) begin
         case (cfg_sel)
            SEL_RED: dur_red_d = cfg_dur;
            SEL_YEL: dur_yel_d = cfg_dur;
            SEL_GRN: dur_grn_d = cfg_dur;
            default: ;
         endcase
      end
   end

   // A write hitting the entry being latched this cycle takes effect for that phase.
   always_comb begin
      case (entry_sel)
         SEL_YEL: entry_dur = dur_yel_q;
         SEL_GRN: entry_dur = dur_grn_q;
         default: entry_dur = dur_red_q;
      endcase
      if (cfg_we && (cfg_sel == entry_sel)) entry_dur = cfg_dur;
      exp_dwell = {1'b0, entry_dur} + (CNT_W+1)'(1);
   end

   always_comb begin
      case (state_q)
         ST_RED:  begin succ_light = LIGHT_YEL; succ_state = ST_YEL; succ_sel = SEL_YEL; end
         ST_YEL:  begin succ_light = LIGHT_GRN; succ_state = ST_GRN; succ_sel = SEL_GRN; end
         default: begin succ_light = LIGHT_RED; succ_state = ST_RED; succ_sel = SEL_RED; end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      fault_code_d  = fault_code_q;
      last_dwell_d  = last_dwell_q;
      phase_done_d  = 1'b0;
      cycle_count_d = cycle_count_q;
      timer_clear   = 1'b0;
      entry_sel     = SEL_RED;
      changed       = (light != light_q);
      legal         = is_one_hot(light);

      case (state_q)
         ST_SYNC: begin
            if (!legal) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_ILLEGAL;
            end else if (light == LIGHT_RED) begin
               state_d     = ST_RED;
               timer_clear = 1'b1;
            end
         end
         ST_RED, ST_YEL, ST_GRN: begin
            if (changed && !legal) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_ILLEGAL;
            end else if (changed && (light != succ_light)) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_ORDER;
            end else if (changed && short_dwell) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_SHORT;
            end else if (long_dwell) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_LONG;
            end else if (changed) begin
               state_d      = succ_state;
               last_dwell_d = dwell;
               phase_done_d = 1'b1;
               timer_clear  = 1'b1;
               entry_sel    = succ_sel;
               if (state_q == ST_GRN) cycle_count_d = cycle_count_q + 8'd1;
            end
         end
         ST_FAULT: begin
            // Only an illegal light can collide with a clear; it re-latches code 1.
            if (err_clear) begin
               if (!legal) begin
                  fault_code_d = FC_ILLEGAL;
               end else begin
                  state_d      = ST_SYNC;
                  fault_d      = 1'b0;
                  fault_code_d = FC_NONE;
               end
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_SYNC;
         light_q       <= LIGHT_RED;
         dur_red_q     <= CNT_W'(DEF_RED);
         dur_yel_q     <= CNT_W'(DEF_YEL);
         dur_grn_q     <= CNT_W'(DEF_GRN);
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         last_dwell_q  <= '0;
         phase_done_q  <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         light_q       <= light;
         dur_red_q     <= dur_red_d;
         dur_yel_q     <= dur_yel_d;
         dur_grn_q     <= dur_grn_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         last_dwell_q  <= last_dwell_d;
         phase_done_q  <= phase_done_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign last_dwell  = last_dwell_q;
   assign phase_done  = phase_done_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// tb/tb_light_sequence_monitor.sv - scoreboard bench for light_sequence_monitor
module tb_light_sequence_monitor;

   localparam int CNT_W = 5;
   localparam logic [2:0] RED = 3'b001;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b100;
   localparam int K_DONE  = 0;
   localparam int K_FAULT = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             tick;
   logic [2:0]       light;
   logic             cfg_we;
   logic [1:0]       cfg_sel;
   logic [CNT_W-1:0] cfg_dur;
   logic             err_clear;
   logic             fault;
   logic [2:0]       fault_code;
   logic [CNT_W:0]   last_dwell;
   logic             phase_done;
   logic [7:0]       cycle_count;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic fault_prev = 1'b0;

   light_sequence_monitor #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .light       (light),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_dur     (cfg_dur),
      .err_clear   (err_clear),
      .fault       (fault),
      .fault_code  (fault_code),
      .last_dwell  (last_dwell),
      .phase_done  (phase_done),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_done(input int d, input int c);
      exp_t e;
      e.kind = K_DONE; e.val = d; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic push_fault(input int code);
      exp_t e;
      e.kind = K_FAULT; e.val = code; e.cyc = 0;
      sb.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk);
      end
      tick = 1'b0;
   endtask

   task automatic set_light(input logic [2:0] v);
      light = v;
      @(negedge clk);
   endtask

   task automatic go(input logic [2:0] nl, input int d, input int c);
      push_done(d, c);
      set_light(nl);
   endtask

   // Monitor: pops one expectation per phase_done pulse or fault rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            fault_prev = 1'b0;
         end else begin
            if (phase_done) begin
               if (sb.size() == 0) chk("spurious_phase_done", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("event_kind_done", K_DONE, e.kind);
                  chk("last_dwell", int'(last_dwell), e.val);
                  chk("cycle_count", int'(cycle_count), e.cyc);
               end
            end
            if (fault && !fault_prev) begin
               if (sb.size() == 0) chk("spurious_fault", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("event_kind_fault", K_FAULT, e.kind);
                  chk("fault_code", int'(fault_code), e.val);
               end
            end
            fault_prev = fault;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog_timeout actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; tick = 1'b0; light = RED; cfg_we = 1'b0; cfg_sel = 2'd0;
      cfg_dur = '0; err_clear = 1'b0;
      cyc(3);
      chk("rst_fault", int'(fault), 0);
      chk("rst_fault_code", int'(fault_code), 0);
      chk("rst_last_dwell", int'(last_dwell), 0);
      chk("rst_phase_done", int'(phase_done), 0);
      chk("rst_cycle_count", int'(cycle_count), 0);
      reset = 1'b0;
      cyc(2);

      // legal cycle with default table
      do_ticks(11); go(YEL, 11, 0); do_ticks(4); go(GRN, 4, 0); do_ticks(11); go(RED, 11, 1);
      chk("legal_no_fault", int'(fault), 0);

      // tolerance edges on RED
      do_ticks(10); go(YEL, 10, 1); do_ticks(4); go(GRN, 4, 1); do_ticks(11); go(RED, 11, 2);
      do_ticks(12); go(YEL, 12, 2); do_ticks(4); go(GRN, 4, 2); do_ticks(11); go(RED, 11, 3);
      do_ticks(9); push_fault(3); set_light(YEL);
      chk("short_fault", int'(fault), 1);
      err_clear = 1'b1; cyc(1); err_clear = 1'b0;
      chk("short_cleared", int'(fault), 0);
      chk("short_cleared_code", int'(fault_code), 0);

      // long dwell raised without a light change
      light = RED; reset = 1'b1; cyc(1); reset = 1'b0; cyc(2);
      do_ticks(12);
      chk("long_tick12_no_fault", int'(fault), 0);
      push_fault(4); do_ticks(1);
      chk("long_tick13_fault", int'(fault), 1);
      err_clear = 1'b1; cyc(1); err_clear = 1'b0; cyc(2);

      // order violation, clear, resynchronise
      do_ticks(11); push_fault(2); set_light(GRN);
      chk("order_fault", int'(fault), 1);
      err_clear = 1'b1; cyc(1); err_clear = 1'b0;
      chk("order_cleared", int'(fault), 0);
      cyc(2);
      set_light(RED);
      do_ticks(11); go(YEL, 11, 0);

      // illegal encoding; clear collides with 000
      do_ticks(2); push_fault(1); set_light(3'b011);
      err_clear = 1'b1; light = 3'b000; cyc(1); err_clear = 1'b0;
      chk("clear_vs_illegal_fault", int'(fault), 1);
      chk("clear_vs_illegal_code", int'(fault_code), 1);
      light = RED; err_clear = 1'b1; cyc(1); err_clear = 1'b0; cyc(2);
      chk("illegal_cleared", int'(fault), 0);

      // config write mid-YELLOW latches only for the next YELLOW
      do_ticks(11); go(YEL, 11, 0);
      do_ticks(2); cfg_we = 1'b1; cfg_sel = 2'd1; cfg_dur = 5'd6; cyc(1); cfg_we = 1'b0;
      do_ticks(2); go(GRN, 4, 0);
      do_ticks(11); go(RED, 11, 1);
      cfg_we = 1'b1; cfg_sel = 2'd3; cfg_dur = 5'd0; cyc(1); cfg_we = 1'b0;
      do_ticks(11); go(YEL, 11, 1); do_ticks(7); go(GRN, 7, 1); do_ticks(11); go(RED, 11, 2);

      for (int k = 3; k <= 5; k++) begin
         do_ticks(11); go(YEL, 11, k - 1); do_ticks(7); go(GRN, 7, k - 1);
         do_ticks(11); go(RED, 11, k);
      end
      do_ticks(11); go(YEL, 11, 5); do_ticks(7); go(GRN, 7, 5); do_ticks(5);
      chk("pre_reset_cycle_count", int'(cycle_count), 5);

      // asynchronous reset mid-GREEN, checked before the next rising edge
      #2 reset = 1'b1;
      #1;
      chk("async_fault", int'(fault), 0);
      chk("async_fault_code", int'(fault_code), 0);
      chk("async_last_dwell", int'(last_dwell), 0);
      chk("async_phase_done", int'(phase_done), 0);
      chk("async_cycle_count", int'(cycle_count), 0);
      cyc(2);
      reset = 1'b0;
      cyc(3);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
